vector_loader: RTL
==================

// Module: vector_loader
// PURPOSE
//  Host-side writer for the dot-product engine. Accepts 2*N bytes over a valid/ready stream,
//  writes A to mem addr 0..N-1 and B to N..2N-1 of MEM16x8, then pulses dp_start.
//  It waits for dp_done, captures dp_result and returns it over a valid/ready result port.
//  mem_own steers the top-level memory mux: 1 = loader drives memory, 0 = engine drives it.
// PARAMETERS
//  ADDR_W  4  memory address width; DEPTH = 2**ADDR_W = 16 bytes per job (N = DEPTH/2 = 8)
//  DATA_W  8  byte, vector element and result width
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  in_valid      in   1       host byte valid
//  in_ready      out  1       loader accepts a byte when in_valid && in_ready
//  in_data       in   DATA_W  host byte; k-th accepted byte of a job goes to address k
//  mem_own       out  1       1 = loader owns memory port
//  mem_wr        out  1       memory write strobe, one cycle per byte
//  mem_addr      out  ADDR_W  memory address
//  mem_data_out  out  DATA_W  memory write data
//  mem_data_in   in   DATA_W  memory asynchronous read data (used by readback only)
//  dp_start      out  1       one-cycle start pulse to the engine
//  dp_done       in   1       engine completion
//  dp_result     in   DATA_W  engine result, valid while dp_done=1
//  out_valid     out  1       result available
//  out_ready     in   1       host takes the result when out_valid && out_ready
//  out_result    out  DATA_W  captured result (0 on readback error)
//  err           out  1       readback mismatch for the current job (0 if READBACK off)
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0, including in_ready.
//    State goes to LOAD and cnt to 0. Reset mid-job discards partial data. dp_start never fires out of reset.
//  - States: LOAD -> DRAIN -> [VERIFY] -> START -> WAIT -> HOLD -> LOAD.
//  - LOAD: in_ready=1 and mem_own=1 (in_ready rises on the first edge after rst falls).
//    On each accept at edge E, the cycle after E has mem_wr=1, mem_addr=cnt, mem_data_out=in_data. cnt++.
//    If there is no accept, mem_wr=0 and cnt holds. Gaps in in_valid are legal.
//    The accept at cnt=DEPTH-1 drops in_ready on that same edge and moves to DRAIN.
//  - DRAIN: one cycle. The last write (addr DEPTH-1) is on the bus, mem_own=1.
//  - START: one cycle. dp_start=1, mem_own=0, mem_wr=0.
//  - WAIT: mem_own=0. On the edge that samples dp_done=1: out_result<=dp_result, out_valid<=1, go to HOLD.
//  - HOLD: out_valid=1 and out_result stable until out_ready. On that edge: out_valid<=0, in_ready<=1,
//    mem_own<=1, cnt<=0, go to LOAD.
//  - Minimum latency: last byte accepted -> dp_start high 2 cycles later (no readback).
//  - Boundaries:
//    - in_valid outside LOAD is ignored and never written.
//    - dp_done outside WAIT is ignored.
//    - out_ready with out_valid=0 is ignored.
//    - out_ready in HOLD while in_valid=1 does not accept a byte on that edge.
//    - cnt wraps only via the job reset to 0, never mid-job.
//  - Arithmetic: cnt is ADDR_W+1 bits. The readback checksum is a DATA_W-bit sum, modulo 2**DATA_W.
//  - err is sticky for the job. It clears on the first accept of the next job or on rst.
// CONFIGURATION
//  - LOADER_READBACK_EN defined: VERIFY is inserted after DRAIN.
//    - During loading, wsum accumulates each written byte.
//    - VERIFY takes DEPTH cycles with mem_own=1, mem_wr=0, mem_addr=0..DEPTH-1; rsum accumulates mem_data_in.
//    - The next cycle compares the sums. Equal: go to START. Unequal: err<=1, out_result<=0,
//      out_valid<=1, go to HOLD, and dp_start is not pulsed.
//  - LOADER_READBACK_EN undefined: no VERIFY state, no sum logic, err tied to 0.
// STRUCTURE
//  - Shared header vector_loader_defs.vh: state encodings, DEPTH and N derivation, width constants,
//    shared with dot_product_computation and the top-level mux.
//  - One sub-module, compiled only with the macro: loader_readback_chk.
//    It holds the wsum/rsum accumulators and the compare, and outputs match.
// TESTING (bench supplies a 16x8 memory model and a behavioural engine model)
//  1. Bytes 1..8, then eight 2s, in_valid held high -> addresses 0..15 written in order;
//     dp_start 2 cycles after the last accept; out_result=72, out_valid=1.
//  2. A=10,20,30,0..., B=5,3,2,0... -> out_result=170, err=0.
//  3. in_valid toggled 1/0 each cycle -> exactly 16 mem_wr pulses at contiguous addresses 0..15,
//     and nothing written on idle cycles.
//  4. rst pulsed after 5 accepts -> all outputs 0. Next job writes from addr 0, and no dp_start is
//     issued for the aborted job.
//  5. out_ready held low 20 cycles, plus a spurious dp_done in HOLD -> out_valid and out_result
//     stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle.
//  6. (LOADER_READBACK_EN) memory model corrupts addr 9 -> err=1, out_result=0, dp_start never high.

Source files
------------

// File: rtl/vector_loader_pkg.sv
// Shared types and constants for the vector loader and its readback checker.
// Holds the FSM state encoding, default widths and the job depth derivation.
// No logic; imported by every file of the loader.
package vector_loader_pkg;

   localparam int ADDR_W_DEF = 4;
   localparam int DATA_W_DEF = 8;

   // LOAD must stay at encoding 0: it is the reset state.
   typedef enum logic [2:0] {
      ST_LOAD   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_VERIFY = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_HOLD   = 3'd5
   } state_t;

   // Bytes per job: A occupies the lower half of memory, B the upper half.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/vector_loader_readback_chk.sv
// Readback checker: sums bytes written during load and bytes read back during verify.
// Ports: clk/rst, clr (job restart), wr_en/wr_data (written bytes), rd_en/rd_data (read-back
// bytes), match (combinational wsum == rsum). Sums are modulo 2**DATA_W.
// Only compiled when LOADER_READBACK_EN is defined; latency 1 cycle per accumulate.
`ifdef LOADER_READBACK_EN
module loader_readback_chk
   import vector_loader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              match
);

   logic [DATA_W-1:0] wsum;
   logic [DATA_W-1:0] rsum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wsum <= '0;
         rsum <= '0;
      end else if (clr) begin
         wsum <= '0;
         rsum <= '0;
      end else begin
         if (wr_en) wsum <= wsum + wr_data;
         if (rd_en) rsum <= rsum + rd_data;
      end
   end

   assign match = (wsum == rsum);

endmodule
`endif

// File: rtl/vector_loader.sv
// Vector loader: streams 2*N host bytes into memory (A at 0..N-1, B at N..2N-1), starts the
// dot-product engine, captures its result and returns it on a valid/ready port.
// Latency: last accepted byte -> dp_start 2 cycles later (DEPTH+3 with readback verify).
// Backpressure: in_ready only high while loading; result held until out_ready.
// Ports: clk, rst (async high); in_valid/in_ready/in_data host stream; mem_own/mem_wr/
// mem_addr/mem_data_out/mem_data_in memory port; dp_start/dp_done/dp_result engine handshake;
// out_valid/out_ready/out_result result stream; err readback mismatch flag.
// Optional feature: LOADER_READBACK_EN inserts a memory readback checksum before start.
module vector_loader
   import vector_loader_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              mem_own,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_data_in,
   output logic              dp_start,
   input  logic              dp_done,
   input  logic [DATA_W-1:0] dp_result,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              in_ready_d, mem_own_d, mem_wr_d, dp_start_d, out_valid_d, err_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_data_out_d, out_result_d;
   logic              accept;

   // in_ready is a register, so a byte is only taken while it is already high.
   assign accept = in_valid && in_ready && (state == ST_LOAD);

`ifdef LOADER_READBACK_EN
   logic sum_clr;
   logic rd_en;
   logic match;

   loader_readback_chk #(.DATA_W(DATA_W)) u_chk (
      .clk     (clk),
      .rst     (rst),
      .clr     (sum_clr),
      .wr_en   (accept),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_data (mem_data_in),
      .match   (match)
   );
`else
   logic unused_rd_data;
   assign unused_rd_data = ^mem_data_in;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_LOAD;
         cnt          <= '0;
         in_ready     <= 1'b0;
         mem_own      <= 1'b0;
         mem_wr       <= 1'b0;
         mem_addr     <= '0;
         mem_data_out <= '0;
         dp_start     <= 1'b0;
         out_valid    <= 1'b0;
         out_result   <= '0;
         err          <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         in_ready     <= in_ready_d;
         mem_own      <= mem_own_d;
         mem_wr       <= mem_wr_d;
         mem_addr     <= mem_addr_d;
         mem_data_out <= mem_data_out_d;
         dp_start     <= dp_start_d;
         out_valid    <= out_valid_d;
         out_result   <= out_result_d;
         err          <= err_d;
      end
   end

   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      mem_wr_d       = 1'b0;
      mem_addr_d     = mem_addr;
      mem_data_out_d = mem_data_out;
      out_valid_d    = out_valid;
      out_result_d   = out_result;
      err_d          = err;
`ifdef LOADER_READBACK_EN
      sum_clr        = 1'b0;
      rd_en          = 1'b0;
`endif

      case (state)
         ST_LOAD: begin
            if (accept) begin
               mem_wr_d       = 1'b1;
               mem_addr_d     = cnt[ADDR_W-1:0];
               mem_data_out_d = in_data;
               cnt_d          = cnt + 1'b1;
               // err belongs to the previous job until new data arrives.
               if (cnt == '0) err_d = 1'b0;
               if (cnt == LAST_IDX) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
`ifdef LOADER_READBACK_EN
            state_d    = ST_VERIFY;
            cnt_d      = '0;
            mem_addr_d = '0;
`else
            state_d    = ST_START;
`endif
         end
`ifdef LOADER_READBACK_EN
         // cnt 0..DEPTH-1 read one address each; cnt == DEPTH is the compare cycle.
         ST_VERIFY: begin
            if (cnt < DEPTH_C) begin
               rd_en = 1'b1;
               cnt_d = cnt + 1'b1;
               if (cnt < LAST_IDX) mem_addr_d = cnt[ADDR_W-1:0] + 1'b1;
            end else if (match) begin
               state_d = ST_START;
            end else begin
               err_d        = 1'b1;
               out_result_d = '0;
               out_valid_d  = 1'b1;
               state_d      = ST_HOLD;
            end
         end
`endif
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (dp_done) begin
               out_result_d = dp_result;
               out_valid_d  = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = ST_LOAD;
`ifdef LOADER_READBACK_EN
               sum_clr     = 1'b1;
`endif
            end
         end
         default: begin
            state_d = ST_LOAD;
            cnt_d   = '0;
         end
      endcase

      // Registered outputs follow the state being entered, so they line up with it.
      in_ready_d = (state_d == ST_LOAD);
      mem_own_d  = (state_d == ST_LOAD) || (state_d == ST_DRAIN) || (state_d == ST_VERIFY);
      dp_start_d = (state_d == ST_START);
   end

endmodule
